// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared constants and state encoding for the wide adder arbiter
package wide_add_pkg;

  localparam int WORD_W = 16;
  localparam int ID_W   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add16_cin.sv
// rtl/add16_cin.sv - combinational 16-bit carry-select adder slice with carry in
module add16_cin
  import wide_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int HALF = WORD_W / 2;

  logic [HALF-1:0] lo_sum;
  logic            lo_cout;
  logic            c;
  logic [HALF:0]   hi_c0;
  logic [HALF:0]   hi_c1;

  always_comb begin
    lo_sum = '0;
    c      = cin;
    for (int i = 0; i < HALF; i++) begin
      lo_sum[i] = a[i] ^ b[i] ^ c;
      c         = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    lo_cout = c;
  end

  // Both upper-byte results are formed up front; the lower carry only steers the mux.
  assign hi_c0 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]};
  assign hi_c1 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};

  always_comb begin
    sum  = {hi_c0[HALF-1:0], lo_sum};
    cout = hi_c0[HALF];
    if (lo_cout) begin
      sum  = {hi_c1[HALF-1:0], lo_sum};
      cout = hi_c1[HALF];
    end
  end

endmodule

// File: rtl/wide_add_arb.sv
// rtl/wide_add_arb.sv - round-robin arbiter sequencing a shared 16-bit slice over multi-word add/sub
module wide_add_arb #(
  parameter int WORDS  = 4,
  parameter int WORD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [WORDS*WORD_W-1:0] req0_a,
  input  logic [WORDS*WORD_W-1:0] req0_b,
  input  logic                    req0_sub,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [WORDS*WORD_W-1:0] req1_a,
  input  logic [WORDS*WORD_W-1:0] req1_b,
  input  logic                    req1_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] out_sum,
  output logic                    out_cout,
  output logic                    out_ovf,
  output logic                    out_id,
  output logic                    busy
);

  import wide_add_pkg::*;

  localparam int W     = WORDS * WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state_q, state_d;
  logic              rr_ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic [ID_W-1:0]   id_q;
  logic              cout_q;
  logic              ovf_q;
  logic [WORD_W-1:0] a_q   [WORDS];
  logic [WORD_W-1:0] b_q   [WORDS];
  logic [WORD_W-1:0] res_q [WORDS];

  logic              gnt_any;
  logic              gnt_id;
  logic              accept;
  logic [W-1:0]      sel_a;
  logic [W-1:0]      sel_beff;
  logic              sel_sub;
  logic [WORD_W-1:0] slice_sum;
  logic              slice_cout;
  logic              a_top;
  logic              b_top;

  // The round-robin pointer names the preferred requester; fall back to the other one.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = rr_ptr_q;
    if (rr_ptr_q ? !req1_valid : !req0_valid) begin
      gnt_id = ~rr_ptr_q;
    end
  end

  assign accept     = (state_q == IDLE) && gnt_any;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  always_comb begin
    sel_a    = gnt_id ? req1_a   : req0_a;
    sel_sub  = gnt_id ? req1_sub : req0_sub;
    sel_beff = gnt_id ? req1_b   : req0_b;
    if (sel_sub) begin
      sel_beff = ~sel_beff;
    end
  end

  add16_cin u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign a_top = a_q[WORDS-1][WORD_W-1];
  assign b_top = b_q[WORDS-1][WORD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1: the inverted B is latched and the carry seeded with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      id_q     <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < WORDS; i++) begin
        a_q[i] <= sel_a[i*WORD_W +: WORD_W];
        b_q[i] <= sel_beff[i*WORD_W +: WORD_W];
      end
      carry_q  <= sel_sub;
      id_q     <= gnt_id;
      idx_q    <= '0;
      rr_ptr_q <= ~gnt_id;
    end else if (state_q == RUN) begin
      res_q[idx_q] <= slice_sum;
      carry_q      <= slice_cout;
      idx_q        <= idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        cout_q <= slice_cout;
        ovf_q  <= (a_top == b_top) && (slice_sum[WORD_W-1] != a_top);
      end
    end
  end

  always_comb begin
    out_sum = '0;
    for (int i = 0; i < WORDS; i++) begin
      out_sum[i*WORD_W +: WORD_W] = res_q[i];
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_id    = id_q;

endmodule
